// File: rtl/instr_fetch_queue.sv
// Fetch stage around the PC register: one imem read per PC, returned words queued with their PCs for decode.
// Latency: pc_next is combinational; a word reaches inst_valid the cycle after its imem_rvalid (2 cycles/instr best case).
// Backpressure: no request is issued while the queue is full; decode stalls via inst_ready; a redirect flushes everything.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DISCARD   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     req_pc;
    logic [31:0]     q_inst [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            fire;

    assign imem_addr = pc_cur;
    assign fire      = imem_req & imem_gnt;

    // Request FSM: at most one read in flight; a redirect mid-read turns the pending response into garbage to drop.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                imem_req = (count < FULL) & ~redirect_valid;
                if (imem_req && imem_gnt) begin
                    state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (imem_rvalid) begin
                    push      = ~redirect_valid;
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            imem_req = 1'b0;
            push     = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember which PC the outstanding read belongs to.
    always_ff @(posedge clk) begin
        if (fire) begin
            req_pc <= pc_cur;
        end
    end

    // Next PC: reset wins, then redirect (word aligned), then advance on grant, else hold.
    always_comb begin
        pc_next = pc_cur;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            pc_next = pc_cur + 32'd4;
        end
    end

    // Queue head presentation; a redirect cycle hides the head so decode cannot consume a flushed entry.
    assign inst_valid = ~reset & (count != '0) & ~redirect_valid;
    assign pop        = inst_valid & inst_ready;
    assign inst       = (count != '0) ? q_inst[rd_ptr] : NOP;
    assign inst_pc    = (count != '0) ? q_pc[rd_ptr]   : 32'h0;

    // Queue pointers and occupancy; redirect flushes at the next edge.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage; push is already suppressed during reset and redirect.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a PC register, an imem responder and a scoreboard monitor.
// Latency: responses are returned one cycle after grant unless held back by the test.
// Backpressure: inst_ready and imem_gnt are driven per test.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          grants;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    logic        pending;
    logic        resp_hold;
    logic        expect_drop;
    logic [31:0] pend_addr;
    logic [31:0] pcn;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Mid-cycle: settle, account for a response this cycle, record any grant, sample pc_next.
    task automatic pre();
        #1;
        if (imem_rvalid) begin
            if (!reset && !redirect_valid && !expect_drop)
                exp_q.push_back({pend_addr, memw(pend_addr)});
            pending     = 1'b0;
            expect_drop = 1'b0;
        end
        if (!reset && imem_req && imem_gnt) begin
            grants++;
            pending   = 1'b1;
            pend_addr = pc_cur;
        end
        pcn = pc_next;
    endtask

    // Advance to the next cycle: PC register update and response drive.
    task automatic post();
        @(posedge clk);
        @(negedge clk);
        pc_cur = pcn;
        if (pending && !resp_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        pending        = 1'b0;
        expect_drop    = 1'b0;
        resp_hold      = 1'b0;
        imem_rvalid    = 1'b0;
        pc_cur         = 32'h0000_0040;
        for (int i = 0; i < 2; i++) begin
            pre();
            chk("rst_pc_next", pc_next, RESET_PC);
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            post();
        end
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        #2;
        if (!reset && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h inst %h, expected no output", inst_pc, inst);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", inst_pc, mon_e[63:32]);
                chk("pop_inst", inst, mon_e[31:0]);
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; grants = 0;
        pending = 1'b0; resp_hold = 1'b0; expect_drop = 1'b0;
        pend_addr = 32'h0; pcn = 32'h0;
        reset = 1'b1; pc_cur = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        @(negedge clk);

        // 1: streaming fetch from 0 with decode always ready.
        imem_gnt = 1'b1; inst_ready = 1'b1;
        do_reset();
        pre();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_pc_next", pc_next, 32'h4);
        chk("t1_empty_valid", 32'(inst_valid), 32'd0);
        chk("t1_empty_inst", inst, 32'h0000_0013);
        chk("t1_empty_pc", inst_pc, 32'h0);
        post();
        pre();
        chk("t1_wait_req", 32'(imem_req), 32'd0);
        chk("t1_wait_hold", pc_next, 32'h4);
        post();
        pre(); chk("t1_addr4", imem_addr, 32'h4); post();
        cyc();
        pre(); chk("t1_addr8", imem_addr, 32'h8); post();
        repeat (3) cyc();
        imem_gnt = 1'b0;
        repeat (4) cyc();
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        // 2: decode stalled fills the queue, then drains and fetch resumes.
        imem_gnt = 1'b1; inst_ready = 1'b0;
        do_reset();
        grants = 0;
        repeat (11) cyc();
        pre();
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_full_req", 32'(imem_req), 32'd0);
        chk("t2_full_hold", pc_next, 32'h10);
        chk("t2_head_valid", 32'(inst_valid), 32'd1);
        chk("t2_head_pc", inst_pc, 32'h0);
        post();
        inst_ready = 1'b1;
        repeat (12) cyc();
        chk("t2_resume", 32'(grants > 4), 32'd1);
        imem_gnt = 1'b0;
        repeat (6) cyc();
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // 3: redirect while a read is outstanding; its late word is discarded.
        imem_gnt = 1'b1; inst_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        pre(); chk("t3_addr4", imem_addr, 32'h4); resp_hold = 1'b1; post();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        pre();
        chk("t3_redir_pc", pc_next, 32'h100);
        chk("t3_redir_req", 32'(imem_req), 32'd0);
        chk("t3_redir_valid", 32'(inst_valid), 32'd0);
        exp_q.delete();
        expect_drop = 1'b1;
        post();
        redirect_valid = 1'b0;
        pre();
        chk("t3_flushed", 32'(inst_valid), 32'd0);
        chk("t3_discard_req", 32'(imem_req), 32'd0);
        resp_hold = 1'b0;
        post();
        pre(); chk("t3_drop_req", 32'(imem_req), 32'd0); post();
        inst_ready = 1'b1;
        pre();
        chk("t3_new_req", 32'(imem_req), 32'd1);
        chk("t3_new_addr", imem_addr, 32'h100);
        post();
        repeat (4) cyc();
        imem_gnt = 1'b0;
        repeat (4) cyc();
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // 4: redirect coinciding with the response drops the word and returns to IDLE.
        imem_gnt = 1'b1; inst_ready = 1'b1;
        do_reset();
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        pre(); chk("t4_redir_pc", pc_next, 32'h200); post();
        redirect_valid = 1'b0;
        pre();
        chk("t4_valid", 32'(inst_valid), 32'd0);
        chk("t4_idle_req", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        post();
        imem_gnt = 1'b0;
        repeat (4) cyc();
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // 5: PC wraps from the top of the address space.
        imem_gnt = 1'b1; inst_ready = 1'b1;
        do_reset();
        pc_cur = 32'hFFFF_FFFC;
        pre();
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        chk("t5_wrap", pc_next, 32'h0);
        post();
        imem_gnt = 1'b0;
        repeat (4) cyc();
        chk("t5_drain", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-read; the stray response after reset is ignored.
        imem_gnt = 1'b1; inst_ready = 1'b1;
        do_reset();
        pc_cur = 32'h0000_0040;
        pre(); resp_hold = 1'b1; post();
        reset = 1'b1;
        pre();
        chk("t6_rst_pc", pc_next, RESET_PC);
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_valid", 32'(inst_valid), 32'd0);
        post();
        cyc();
        reset = 1'b0; imem_gnt = 1'b0; expect_drop = 1'b1; resp_hold = 1'b0;
        cyc();
        cyc();
        pre();
        chk("t6_stray_valid", 32'(inst_valid), 32'd0);
        chk("t6_idle_req", 32'(imem_req), 32'd1);
        chk("t6_hold_pc", pc_next, RESET_PC);
        post();
        repeat (2) cyc();
        chk("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
